// File: rtl/qs_out_chk.sv
// qs_out_chk: egress stream checker for the qs sorter with per-packet order/framing/length/error verdicts
module qs_out_chk #(
  parameter int W = 32,
  parameter int N = 16,
  parameter int DESCEND = 0,
  parameter int LQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic                       in_rdy_r,
  input  logic                       out_vld_r,
  input  logic                       out_sop_r,
  input  logic                       out_eop_r,
  input  logic                       out_err_r,
  input  logic [W-1:0]               out_dat_r,
  output logic                       chk_done_r,
  output logic                       chk_pass_r,
  output logic [$clog2(N+1)-1:0]     chk_len_r,
  output logic                       chk_err_order_r,
  output logic                       chk_err_frame_r,
  output logic                       chk_err_len_r,
  output logic                       chk_err_dut_r,
  output logic                       chk_busy_r,
  output logic                       chk_lq_ovf_r,
  output logic [31:0]                chk_pkt_cnt_r,
  output logic [31:0]                chk_fail_cnt_r
);
  localparam int CW = $clog2(N + 1);
  localparam int LW = $clog2(N + 2);
  localparam int AW = $clog2(LQ_DEPTH);
  localparam int QW = $clog2(LQ_DEPTH + 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [W-1:0] prev, prev_n;
  logic [CW-1:0] len, len_n, v_len, act_len;
  logic [3:0] e, e_n, v_e, act_e, f;
  logic v, v_pop, ord, ovr, lerr;
  logic [LW-1:0] icnt, icnt_n;
  logic [LW-1:0] q [LQ_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [QW-1:0] qc;
  logic acc, push, push_ok, pop, full, empty;
  assign acc = in_vld && in_rdy_r;
  assign push = acc && in_eop;
  assign empty = qc == '0;
  assign full = qc == QW'(LQ_DEPTH);
  assign pop = v_pop && !empty;
  assign push_ok = push && (!full || pop);
  assign icnt_n = in_sop ? LW'(1) : icnt == LW'(N + 1) ? icnt : icnt + LW'(1);
  always_comb begin
    ord = DESCEND != 0 ? out_dat_r > prev : out_dat_r < prev;
    ovr = len == CW'(N);
    act_len = ovr ? len : len + CW'(1);
    act_e = e | {out_err_r, ovr, 1'b0, ord};
    state_n = state;
    prev_n = prev;
    len_n = len;
    e_n = e;
    v = 1'b0;
    v_pop = 1'b0;
    v_len = '0;
    v_e = '0;
    if (out_vld_r) begin
      if (state == ACTIVE && !out_sop_r) begin
        prev_n = out_dat_r;
        len_n = act_len;
        e_n = act_e;
        v = out_eop_r;
        v_pop = out_eop_r;
        v_len = act_len;
        v_e = act_e;
        state_n = out_eop_r ? IDLE : ACTIVE;
      end else if (out_sop_r) begin
        prev_n = out_dat_r;
        len_n = CW'(1);
        e_n = {out_err_r, 3'b000};
        v = state == ACTIVE || out_eop_r;
        v_pop = v;
        v_len = state == ACTIVE ? len : CW'(1);
        v_e = state == ACTIVE ? e | 4'b0010 : {out_err_r, 3'b000};
        state_n = out_eop_r ? IDLE : ACTIVE;
      end else begin
        v = 1'b1;
        v_e = {out_err_r, 3'b010};
      end
    end
    lerr = v_pop && (empty || q[rp] != LW'(v_len));
    f = v_e | {1'b0, lerr, 2'b00};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prev <= '0;
      len <= '0;
      e <= '0;
      icnt <= '0;
      wp <= '0;
      rp <= '0;
      qc <= '0;
      chk_done_r <= 1'b0;
      chk_pass_r <= 1'b0;
      chk_len_r <= '0;
      chk_err_order_r <= 1'b0;
      chk_err_frame_r <= 1'b0;
      chk_err_len_r <= 1'b0;
      chk_err_dut_r <= 1'b0;
      chk_busy_r <= 1'b0;
      chk_lq_ovf_r <= 1'b0;
      chk_pkt_cnt_r <= '0;
      chk_fail_cnt_r <= '0;
    end else begin
      state <= state_n;
      prev <= prev_n;
      len <= len_n;
      e <= e_n;
      chk_busy_r <= state_n == ACTIVE;
      if (acc) icnt <= icnt_n;
      if (push_ok) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      qc <= qc + QW'(push_ok) - QW'(pop);
      if (push && full && !pop) chk_lq_ovf_r <= 1'b1;
      chk_done_r <= v;
      if (v) begin
        chk_len_r <= v_len;
        chk_err_order_r <= f[0];
        chk_err_frame_r <= f[1];
        chk_err_len_r <= f[2];
        chk_err_dut_r <= f[3];
        chk_pass_r <= ~|f;
        chk_pkt_cnt_r <= chk_pkt_cnt_r + 32'd1;
        if (|f) chk_fail_cnt_r <= chk_fail_cnt_r + 32'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) q[wp] <= icnt_n;
  end
endmodule

// File: tb/tb_qs_out_chk.sv
// tb_qs_out_chk: directed bench for qs_out_chk with a queue-based reference model
module tb_qs_out_chk;
  localparam int W = 32;
  localparam int N = 16;
  localparam int DESCEND = 0;
  localparam int LQ_DEPTH = 4;
  logic clk, rst;
  logic in_vld, in_sop, in_eop, in_rdy_r;
  logic out_vld_r, out_sop_r, out_eop_r, out_err_r;
  logic [W-1:0] out_dat_r;
  logic chk_done_r, chk_pass_r, chk_err_order_r, chk_err_frame_r, chk_err_len_r, chk_err_dut_r;
  logic chk_busy_r, chk_lq_ovf_r;
  logic [$clog2(N+1)-1:0] chk_len_r;
  logic [31:0] chk_pkt_cnt_r, chk_fail_cnt_r;
  qs_out_chk #(.W(W), .N(N), .DESCEND(DESCEND), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_rdy_r(in_rdy_r),
    .out_vld_r(out_vld_r), .out_sop_r(out_sop_r), .out_eop_r(out_eop_r),
    .out_err_r(out_err_r), .out_dat_r(out_dat_r),
    .chk_done_r(chk_done_r), .chk_pass_r(chk_pass_r), .chk_len_r(chk_len_r),
    .chk_err_order_r(chk_err_order_r), .chk_err_frame_r(chk_err_frame_r),
    .chk_err_len_r(chk_err_len_r), .chk_err_dut_r(chk_err_dut_r),
    .chk_busy_r(chk_busy_r), .chk_lq_ovf_r(chk_lq_ovf_r),
    .chk_pkt_cnt_r(chk_pkt_cnt_r), .chk_fail_cnt_r(chk_fail_cnt_r)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, x, $time);
    end
  endtask
  int iq[$];
  logic [W-1:0] pkt[$];
  int icnt, m_len, m_pc, m_fc;
  bit ovf_m, act, perr, m_done, m_pass, m_ord, m_frm, m_lerr, m_dut;
  function automatic bit bad_order(input logic [W-1:0] p[$]);
    bit b = 0;
    for (int i = 1; i < p.size(); i++)
      b |= DESCEND != 0 ? p[i] > p[i-1] : p[i] < p[i-1];
    return b;
  endfunction
  function void verdict(input int n, input bit o, input bit frm, input bit dopop, input bit d);
    bit l;
    l = n > N;
    m_len = n > N ? N : n;
    if (dopop) begin
      if (iq.size() == 0) l = 1;
      else if (iq.pop_front() != m_len) l = 1;
    end
    m_ord = o;
    m_frm = frm;
    m_lerr = l;
    m_dut = d;
    m_pass = !(o || frm || l || d);
    m_done = 1;
    m_pc++;
    if (!m_pass) m_fc++;
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      iq.delete();
      pkt.delete();
      icnt = 0; ovf_m = 0; act = 0; perr = 0; m_done = 0; m_len = 0; m_pc = 0; m_fc = 0;
      m_pass = 0; m_ord = 0; m_frm = 0; m_lerr = 0; m_dut = 0;
    end else begin
      m_done = 0;
      if (out_vld_r) begin
        if (out_sop_r) begin
          if (act) verdict(pkt.size(), bad_order(pkt), 1, 1, perr);
          if (out_eop_r && !act) verdict(1, 0, 0, 1, out_err_r);
          pkt.delete();
          pkt.push_back(out_dat_r);
          perr = out_err_r;
          act = !out_eop_r;
        end else if (!act) begin
          verdict(0, 0, 1, 0, out_err_r);
        end else begin
          pkt.push_back(out_dat_r);
          perr |= out_err_r;
          if (out_eop_r) begin
            verdict(pkt.size(), bad_order(pkt), 0, 1, perr);
            act = 0;
          end
        end
      end
      if (in_vld && in_rdy_r) begin
        icnt = in_sop ? 1 : icnt + 1;
        if (in_eop) begin
          if (iq.size() == LQ_DEPTH) ovf_m = 1;
          else iq.push_back(icnt > N + 1 ? N + 1 : icnt);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("done", chk_done_r, m_done);
      chk("busy", chk_busy_r, act);
      chk("lq_ovf", chk_lq_ovf_r, ovf_m);
      chk("pkt_cnt", chk_pkt_cnt_r, m_pc);
      chk("fail_cnt", chk_fail_cnt_r, m_fc);
      chk("len", chk_len_r, m_len);
      chk("pass", chk_pass_r, m_pass);
      chk("err_order", chk_err_order_r, m_ord);
      chk("err_frame", chk_err_frame_r, m_frm);
      chk("err_len", chk_err_len_r, m_lerr);
      chk("err_dut", chk_err_dut_r, m_dut);
    end
  end
  task automatic ib(input logic s, input logic e, input logic r);
    @(negedge clk);
    in_vld = 1; in_sop = s; in_eop = e; in_rdy_r = r;
  endtask
  task automatic ob(input logic s, input logic e, input logic r, input logic [W-1:0] d);
    @(negedge clk);
    out_vld_r = 1; out_sop_r = s; out_eop_r = e; out_err_r = r; out_dat_r = d;
  endtask
  task automatic idle;
    @(negedge clk);
    in_vld = 0; in_sop = 0; in_eop = 0;
    out_vld_r = 0; out_sop_r = 0; out_eop_r = 0; out_err_r = 0;
  endtask
  initial begin
    rst = 0;
    in_vld = 0; in_sop = 0; in_eop = 0; in_rdy_r = 1;
    out_vld_r = 0; out_sop_r = 0; out_eop_r = 0; out_err_r = 0; out_dat_r = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", chk_done_r, 0);
    chk("rst_pkt_cnt", chk_pkt_cnt_r, 0);
    chk("rst_busy", chk_busy_r, 0);
    rst = 1;
    // sorted 4-beat packet
    ib(1, 0, 1); ib(0, 0, 1); ib(0, 0, 1); ib(0, 1, 1); idle;
    ob(1, 0, 0, 1); ob(0, 0, 0, 3);
    chk("t1_busy", chk_busy_r, 1);
    ob(0, 0, 0, 7); ob(0, 1, 0, 9); idle;
    chk("t1_done", chk_done_r, 1);
    chk("t1_pass", chk_pass_r, 1);
    chk("t1_len", chk_len_r, 4);
    chk("t1_pkt", chk_pkt_cnt_r, 1);
    chk("t1_fail", chk_fail_cnt_r, 0);
    // order violation
    ib(1, 0, 1); ib(0, 0, 1); ib(0, 0, 1); ib(0, 1, 1); idle;
    ob(1, 0, 0, 1); ob(0, 0, 0, 5); ob(0, 0, 0, 4); ob(0, 1, 0, 9); idle;
    chk("t2_order", chk_err_order_r, 1);
    chk("t2_pass", chk_pass_r, 0);
    chk("t2_fail", chk_fail_cnt_r, 1);
    // orphan beat then equal-valued pair
    ib(1, 0, 1); ib(0, 1, 1); idle;
    ob(0, 0, 0, 5); idle;
    chk("t3_orph_frame", chk_err_frame_r, 1);
    chk("t3_orph_len", chk_len_r, 0);
    chk("t3_orph_pass", chk_pass_r, 0);
    ob(1, 0, 0, 2); ob(0, 1, 0, 2); idle;
    chk("t3_pass", chk_pass_r, 1);
    chk("t3_len", chk_len_r, 2);
    // length mismatch, with one unaccepted ingress beat
    ib(1, 0, 1); ib(0, 0, 0); ib(0, 0, 1); ib(0, 1, 1); idle;
    ob(1, 0, 0, 4); ob(0, 1, 0, 6); idle;
    chk("t4_err_len", chk_err_len_r, 1);
    chk("t4_len", chk_len_r, 2);
    chk("t4_pass", chk_pass_r, 0);
    // back-to-back single-beat packets, middle one flagged by the DUT
    ib(1, 1, 1); ib(1, 1, 1); ib(1, 1, 1); idle;
    ob(1, 1, 0, 10); ob(1, 1, 1, 11); ob(1, 1, 0, 12);
    chk("t6_done2", chk_done_r, 1);
    chk("t6_dut", chk_err_dut_r, 1);
    chk("t6_pass2", chk_pass_r, 0);
    idle;
    chk("t6_done3", chk_done_r, 1);
    chk("t6_pass3", chk_pass_r, 1);
    chk("t6_pkt", chk_pkt_cnt_r, 8);
    // oversize packet: length saturates at N
    for (int i = 0; i <= N; i++) ib(i == 0, i == N, 1);
    idle;
    for (int i = 0; i <= N; i++) ob(i == 0, i == N, 0, W'(i));
    idle;
    chk("sat_len", chk_len_r, N);
    chk("sat_err_len", chk_err_len_r, 1);
    // queue overflow, then async reset mid-packet
    for (int i = 0; i < 5; i++) ib(1, 1, 1);
    idle;
    chk("t5_ovf", chk_lq_ovf_r, 1);
    ob(1, 0, 0, 1); ob(0, 0, 0, 2); idle;
    chk("t5_busy", chk_busy_r, 1);
    #2 rst = 0;
    #1;
    chk("t5_rst_busy", chk_busy_r, 0);
    chk("t5_rst_ovf", chk_lq_ovf_r, 0);
    chk("t5_rst_pkt", chk_pkt_cnt_r, 0);
    chk("t5_rst_fail", chk_fail_cnt_r, 0);
    chk("t5_rst_len", chk_len_r, 0);
    chk("t5_rst_flags", {chk_done_r, chk_pass_r, chk_err_order_r, chk_err_frame_r, chk_err_len_r, chk_err_dut_r}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    ib(1, 1, 1); idle;
    ob(1, 1, 0, 5); idle;
    chk("post_pass", chk_pass_r, 1);
    chk("post_pkt", chk_pkt_cnt_r, 1);
    repeat (2) idle;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
